if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 next_addr_i  input  32  SHALL carry the next PC from the next-address stage: pc+4, or the jump target when branch is taken.
REQ-005 stall_i  input  1  SHALL be the ID-stage hazard stall.
REQ-006 flush_i  input  1  SHALL be the branch-taken redirect/kill request.
REQ-007 imem_ack_i  input  1  SHALL be the one-cycle instruction-memory acknowledge; imem_rdata_i is valid in the same cycle.
REQ-008 imem_rdata_i  input  32  SHALL be the instruction word from memory.
REQ-009 pc_o  output  32  SHALL be the current fetch PC, fed to the next-address stage.
REQ-010 imem_req_o / imem_addr_o  output  1/32  SHALL be the memory request and address; imem_addr_o SHALL equal pc_o.
REQ-011 if_id_pc_o / if_id_inst_o / if_id_valid_o  output  32/32/1  SHALL form the IF/ID pipeline register.
REQ-012 fetch_err_o  output  1  SHALL be the sticky fetch-timeout flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-015 In REQ, imem_req_o SHALL be 1 and imem_addr_o SHALL stay stable until the ack.
REQ-016 In IDLE and HOLD, imem_req_o SHALL be 0.
REQ-017 On REQ with ack, stall_i=0, no kill pending: the block SHALL set if_id_pc_o<=pc_o, if_id_inst_o<=imem_rdata_i, if_id_valid_o<=1 and pc_o<=next_addr_i, and stay in REQ so back-to-back fetches give 1 instruction per cycle.
REQ-018 On REQ with ack and stall_i=1: the block SHALL latch rdata and pc_o into a hold buffer, keep the IF/ID register unchanged, and go to HOLD.
REQ-019 On REQ without ack: if_id_valid_o SHALL clear to 0 (bubble) when stall_i=0; the IF/ID register SHALL hold when stall_i=1.
REQ-020 In HOLD with stall_i=0: the IF/ID register SHALL load from the hold buffer (valid=1), pc_o<=next_addr_i, and the FSM SHALL go to REQ.
REQ-021 flush_i SHALL take priority over stall_i and SHALL clear the IF/ID register on the next edge: valid=0, inst=32'h0 (NOP).
REQ-022 flush_i in REQ with ack in the same cycle: the block SHALL discard rdata and set pc_o<=next_addr_i.
REQ-023 flush_i in REQ without ack: the block SHALL set redirect_pc<=next_addr_i and kill=1, and keep pc_o and imem_addr_o unchanged.
REQ-024 A later ack with kill=1 SHALL be discarded, with pc_o<=redirect_pc and kill<=0.
REQ-025 A repeated flush while kill=1 SHALL overwrite redirect_pc.
REQ-026 flush_i in HOLD: the block SHALL discard the buffer, set pc_o<=next_addr_i and go to REQ.
REQ-027 pc_o SHALL wrap modulo 2^32 and SHALL never change while a request is outstanding.

Reset
REQ-028 On rst_n=0, asynchronously, the block SHALL set pc_o=RESET_PC, imem_req_o=0, if_id_pc_o=0, if_id_inst_o=0, if_id_valid_o=0, kill=0, redirect_pc=0, fetch_err_o=0, timeout counter=0 and state=IDLE.
REQ-029 Reset asserted with a request outstanding SHALL abandon that request; a stale ack after release SHALL be ignored outside REQ.

Configuration
REQ-030 When FETCH_TIMEOUT_EN is defined, a 4-bit counter SHALL increment each REQ cycle without ack and clear on ack; reaching 15 SHALL set fetch_err_o=1, sticky until reset, with fetching continuing.
REQ-031 When FETCH_TIMEOUT_EN is undefined, fetch_err_o SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-032 Reset release with RESET_PC=0, ack every cycle, next_addr_i=pc+4 -> SHALL produce req from cycle 2 and if_id_pc_o sequence 0,4,8,12 with valid=1 each cycle.
REQ-033 stall_i=1 during ack of pc=8 with rdata=0x8C010004, held 3 cycles -> SHALL hold IF/ID at pc=4 with req=0; on stall release SHALL output if_id_pc_o=8, inst=0x8C010004.
REQ-034 flush_i with next_addr_i=0x100 while pc=0x10 outstanding, ack 2 cycles later -> SHALL discard that data, output valid=0, and issue the next request at 0x100.
REQ-035 flush_i and stall_i together with ack -> SHALL give valid=0, pc_o=next_addr_i and state REQ.
REQ-036 With FETCH_TIMEOUT_EN defined and no ack for 15 cycles -> SHALL set fetch_err_o=1, held through later acks until rst_n=0.
REQ-037 pc_o=0xFFFFFFFC with next_addr_i=0 -> SHALL fetch the next request at address 0.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with IF/ID register, hold buffer and redirect.
// Optional macro FETCH_TIMEOUT_EN adds a sticky fetch-timeout flag.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   next_addr_i             next PC (pc+4 or jump target)
//   stall_i, flush_i        ID hazard stall, branch redirect/kill
//   imem_ack_i/rdata_i      one-cycle memory ack with data
//   pc_o                    current fetch PC
//   imem_req_o/addr_o       memory request, address (== pc_o)
//   if_id_pc/inst/valid_o   IF/ID pipeline register
//   fetch_err_o             sticky timeout flag (0 unless FETCH_TIMEOUT_EN)
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_addr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        kill_q, kill_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;
        id_valid_d    = id_valid_q;
        hold_pc_d     = hold_pc_q;
        hold_inst_d   = hold_inst_q;
        redirect_pc_d = redirect_pc_q;
        kill_d        = kill_q;

        // Flush always wins: IF/ID becomes a NOP bubble.
        if (flush_i) begin
            id_pc_d    = 32'h0;
            id_inst_d  = 32'h0;
            id_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        pc_d   = next_addr_i;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        // Data belongs to a squashed fetch: drop it and
                        // resume at the remembered redirect target.
                        pc_d   = redirect_pc_q;
                        kill_d = 1'b0;
                        if (!stall_i) id_valid_d = 1'b0;
                    end else if (stall_i) begin
                        hold_pc_d   = pc_q;
                        hold_inst_d = imem_rdata_i;
                        state_d     = S_HOLD;
                    end else begin
                        id_pc_d    = pc_q;
                        id_inst_d  = imem_rdata_i;
                        id_valid_d = 1'b1;
                        pc_d       = next_addr_i;
                    end
                end else begin
                    // Address must stay stable until the ack, so a
                    // flush here only records the target.
                    if (flush_i) begin
                        redirect_pc_d = next_addr_i;
                        kill_d        = 1'b1;
                    end else if (!stall_i) begin
                        id_valid_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    pc_d    = next_addr_i;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    id_pc_d    = hold_pc_q;
                    id_inst_d  = hold_inst_q;
                    id_valid_d = 1'b1;
                    pc_d       = next_addr_i;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            id_pc_q       <= 32'h0;
            id_inst_q     <= 32'h0;
            id_valid_q    <= 1'b0;
            hold_pc_q     <= 32'h0;
            hold_inst_q   <= 32'h0;
            redirect_pc_q <= 32'h0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            hold_pc_q     <= hold_pc_d;
            hold_inst_q   <= hold_inst_d;
            redirect_pc_q <= redirect_pc_d;
            kill_q        <= kill_d;
        end
    end

    assign pc_o          = pc_q;
    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_inst_o  = id_inst_q;
    assign if_id_valid_o = id_valid_q;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;

    // Counts consecutive unacknowledged request cycles; saturates at 15.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_REQ) begin
            if (imem_ack_i) begin
                tmo_cnt_d = 4'h0;
            end else if (tmo_cnt_q != 4'hF) begin
                tmo_cnt_d = tmo_cnt_q + 4'h1;
            end
        end
        err_d = err_q | (tmo_cnt_d == 4'hF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 4'h0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_addr_i;
    logic        stall_i;
    logic        flush_i;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic        fetch_err_o;

    int total = 0;
    int bad   = 0;

    if_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_addr_i  (next_addr_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .if_id_pc_o   (if_id_pc_o),
        .if_id_inst_o (if_id_inst_o),
        .if_id_valid_o(if_id_valid_o),
        .fetch_err_o  (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ack, input logic [31:0] rd,
                       input logic [31:0] na, input logic st,
                       input logic fl);
        imem_ack_i   = ack;
        imem_rdata_i = rd;
        next_addr_i  = na;
        stall_i      = st;
        flush_i      = fl;
    endtask

    logic exp_err;

    initial begin
`ifdef FETCH_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid_o}, 32'h0);
        chk("rst_inst", if_id_inst_o, 32'h0);
        chk("rst_err", {31'h0, fetch_err_o}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {31'h0, imem_req_o}, 32'h0);

        // IDLE -> REQ after one edge
        step();
        chk("req_on", {31'h0, imem_req_o}, 32'h1);
        chk("req_addr", imem_addr_o, 32'h0);

        // back-to-back fetches
        drv(1'b1, 32'h0000_00A0, 32'h4, 1'b0, 1'b0);
        step();
        chk("f0_pc", if_id_pc_o, 32'h0);
        chk("f0_inst", if_id_inst_o, 32'h0000_00A0);
        chk("f0_valid", {31'h0, if_id_valid_o}, 32'h1);
        chk("f0_npc", pc_o, 32'h4);
        drv(1'b1, 32'h0000_00A4, 32'h8, 1'b0, 1'b0);
        step();
        chk("f1_pc", if_id_pc_o, 32'h4);
        chk("f1_npc", pc_o, 32'h8);

        // stall during ack of pc=8, held three cycles
        drv(1'b1, 32'h8C01_0004, 32'hC, 1'b1, 1'b0);
        step();
        chk("st_idpc", if_id_pc_o, 32'h4);
        chk("st_valid", {31'h0, if_id_valid_o}, 32'h1);
        chk("st_req", {31'h0, imem_req_o}, 32'h0);
        chk("st_pc", pc_o, 32'h8);
        drv(1'b0, 32'h0, 32'hC, 1'b1, 1'b0);
        step();
        step();
        chk("st2_idpc", if_id_pc_o, 32'h4);
        chk("st2_req", {31'h0, imem_req_o}, 32'h0);
        drv(1'b0, 32'h0, 32'hC, 1'b0, 1'b0);
        step();
        chk("rel_idpc", if_id_pc_o, 32'h8);
        chk("rel_inst", if_id_inst_o, 32'h8C01_0004);
        chk("rel_valid", {31'h0, if_id_valid_o}, 32'h1);
        chk("rel_pc", pc_o, 32'hC);
        chk("rel_req", {31'h0, imem_req_o}, 32'h1);

        drv(1'b1, 32'h0000_00B0, 32'h10, 1'b0, 1'b0);
        step();
        chk("f3_idpc", if_id_pc_o, 32'hC);
        chk("f3_pc", pc_o, 32'h10);

        // flush while pc=0x10 outstanding, ack two cycles later
        drv(1'b0, 32'h0, 32'h100, 1'b0, 1'b1);
        step();
        chk("fl_valid", {31'h0, if_id_valid_o}, 32'h0);
        chk("fl_inst", if_id_inst_o, 32'h0);
        chk("fl_addr", imem_addr_o, 32'h10);
        drv(1'b0, 32'h0, 32'h14, 1'b0, 1'b0);
        step();
        chk("fl_hold", pc_o, 32'h10);
        drv(1'b1, 32'hDEAD_BEEF, 32'h14, 1'b0, 1'b0);
        step();
        chk("kill_valid", {31'h0, if_id_valid_o}, 32'h0);
        chk("kill_inst", if_id_inst_o, 32'h0);
        chk("kill_pc", imem_addr_o, 32'h100);
        drv(1'b1, 32'h0000_00C0, 32'h104, 1'b0, 1'b0);
        step();
        chk("rd_idpc", if_id_pc_o, 32'h100);
        chk("rd_inst", if_id_inst_o, 32'h0000_00C0);

        // repeated flush overwrites redirect target
        drv(1'b0, 32'h0, 32'h200, 1'b0, 1'b1);
        step();
        drv(1'b0, 32'h0, 32'h300, 1'b0, 1'b1);
        step();
        chk("rf_pc", pc_o, 32'h104);
        drv(1'b1, 32'h1111_1111, 32'h108, 1'b0, 1'b0);
        step();
        chk("rf_redir", pc_o, 32'h300);
        chk("rf_valid", {31'h0, if_id_valid_o}, 32'h0);

        // flush + stall + ack together
        drv(1'b1, 32'hEE, 32'h400, 1'b1, 1'b1);
        step();
        chk("fs_valid", {31'h0, if_id_valid_o}, 32'h0);
        chk("fs_pc", pc_o, 32'h400);
        chk("fs_req", {31'h0, imem_req_o}, 32'h1);

        // wrap-around
        drv(1'b1, 32'h1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        chk("w0_pc", pc_o, 32'hFFFF_FFFC);
        chk("w0_idpc", if_id_pc_o, 32'h400);
        drv(1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
        step();
        chk("w1_idpc", if_id_pc_o, 32'hFFFF_FFFC);
        chk("w1_addr", imem_addr_o, 32'h0);

        // no ack with stall holds IF/ID, without stall bubbles
        drv(1'b0, 32'h0, 32'h4, 1'b1, 1'b0);
        step();
        chk("na_hold", {31'h0, if_id_valid_o}, 32'h1);
        drv(1'b0, 32'h0, 32'h4, 1'b0, 1'b0);
        step();
        chk("na_bubble", {31'h0, if_id_valid_o}, 32'h0);
        chk("na_pc", pc_o, 32'h0);

        // timeout: clear counter with one ack, then 15 silent cycles
        drv(1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
        step();
        drv(1'b0, 32'h0, 32'h8, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step();
        chk("to14", {31'h0, fetch_err_o}, 32'h0);
        step();
        chk("to15", {31'h0, fetch_err_o}, {31'h0, exp_err});
        drv(1'b1, 32'h4, 32'h8, 1'b0, 1'b0);
        step();
        step();
        chk("to_sticky", {31'h0, fetch_err_o}, {31'h0, exp_err});

        // async reset mid-cycle, stale ack ignored in IDLE
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc_o, 32'h0);
        chk("ar_req", {31'h0, imem_req_o}, 32'h0);
        chk("ar_err", {31'h0, fetch_err_o}, 32'h0);
        chk("ar_valid", {31'h0, if_id_valid_o}, 32'h0);
        #2;
        rst_n = 1'b1;
        drv(1'b1, 32'h5, 32'h4, 1'b0, 1'b0);
        step();
        chk("stale_valid", {31'h0, if_id_valid_o}, 32'h0);
        chk("stale_pc", pc_o, 32'h0);
        step();
        chk("post_idpc", if_id_pc_o, 32'h0);
        chk("post_valid", {31'h0, if_id_valid_o}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
